// File: rtl/fir_seq_pkg.sv
// Shared types and modular address helpers for the FIR MAC sequencer.
// Wrap helpers compare and reload, so any buffer depth works.
package fir_seq_pkg;

    typedef enum logic [2:0] {
        INIT,
        READ,
        MAC,
        DRAIN,
        WRITE
    } state_t;

    // Step an address forward, folding depth-1 back to 0.
    function automatic int wrap_inc(input int addr, input int depth);
        return (addr >= depth - 1) ? 0 : addr + 1;
    endfunction

    // Step an address backward, folding 0 up to depth-1.
    function automatic int wrap_dec(input int addr, input int depth);
        return (addr == 0) ? depth - 1 : addr - 1;
    endfunction

endpackage

// File: rtl/fir_mac_sequencer.sv
// Control FSM for a time-multiplexed FIR: fills the circular sample RAM,
// walks taps through one shared MAC, drains it and pushes one result.
module fir_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int TAPS       = 20,
    parameter int DECIMATION = 1,
    parameter int MAC_LAT    = 2,
    parameter int ADDR_W     = $clog2(TAPS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_empty,
    output logic              in_rd_en,
    output logic              buf_wr_en,
    output logic              buf_zero,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              mac_en,
    output logic              mac_clear,
    input  logic              out_full,
    output logic              out_wr_en,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] TAP_LAST = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] DEC_LAST = ADDR_W'(DECIMATION - 1);
    localparam logic [2:0]        DRN_LAST = 3'(MAC_LAT - 1);

    if (DECIMATION > TAPS || DECIMATION < 1) begin : g_bad_dec
        $error("fir_mac_sequencer: DECIMATION must be in 1..TAPS");
    end

    state_t            state, state_n;
    logic [ADDR_W-1:0] wp, wp_n;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_n;
    logic [ADDR_W-1:0] rd_cnt, rd_cnt_n;
    logic [ADDR_W-1:0] k, k_n;
    logic [2:0]        drain_cnt, drain_cnt_n;

    // State and pointer registers; reset aborts any pass in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            wp        <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            k         <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            wp        <= wp_n;
            rd_ptr    <= rd_ptr_n;
            rd_cnt    <= rd_cnt_n;
            k         <= k_n;
            drain_cnt <= drain_cnt_n;
        end
    end

    // Next-state and strobe decode; outputs forced low while in reset.
    always_comb begin
        state_n     = state;
        wp_n        = wp;
        rd_ptr_n    = rd_ptr;
        rd_cnt_n    = rd_cnt;
        k_n         = k;
        drain_cnt_n = drain_cnt;
        in_rd_en    = 1'b0;
        buf_wr_en   = 1'b0;
        buf_zero    = 1'b0;
        buf_wr_addr = '0;
        buf_rd_addr = '0;
        coef_addr   = '0;
        mac_en      = 1'b0;
        mac_clear   = 1'b0;
        out_wr_en   = 1'b0;
        busy        = 1'b1;

        unique case (state)
            INIT: begin
                buf_wr_en   = 1'b1;
                buf_zero    = 1'b1;
                buf_wr_addr = k;
                if (k == TAP_LAST) begin
                    k_n     = '0;
                    wp_n    = '0;
                    state_n = READ;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            READ: begin
                in_rd_en    = !in_empty;
                buf_wr_en   = !in_empty;
                buf_wr_addr = wp;
                busy        = (rd_cnt != '0);
                if (!in_empty) begin
                    wp_n = ADDR_W'(wrap_inc(int'(wp), TAPS));
                    if (rd_cnt == DEC_LAST) begin
                        // Slot just written is the newest sample: tap 0.
                        rd_cnt_n = '0;
                        k_n      = '0;
                        rd_ptr_n = wp;
                        state_n  = MAC;
                    end else begin
                        rd_cnt_n = rd_cnt + 1'b1;
                    end
                end
            end
            MAC: begin
                mac_en      = 1'b1;
                mac_clear   = (k == '0);
                coef_addr   = k;
                buf_rd_addr = rd_ptr;
                rd_ptr_n    = ADDR_W'(wrap_dec(int'(rd_ptr), TAPS));
                if (k == TAP_LAST) begin
                    k_n = '0;
                    if (MAC_LAT == 0) begin
                        state_n = WRITE;
                    end else begin
                        drain_cnt_n = '0;
                        state_n     = DRAIN;
                    end
                end else begin
                    k_n = k + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRN_LAST) begin
                    drain_cnt_n = '0;
                    state_n     = WRITE;
                end else begin
                    drain_cnt_n = drain_cnt + 1'b1;
                end
            end
            WRITE: begin
                out_wr_en = !out_full;
                if (!out_full) begin
                    state_n = READ;
                end
            end
            default: begin
                state_n = INIT;
            end
        endcase

        if (!reset) begin
            in_rd_en    = 1'b0;
            buf_wr_en   = 1'b0;
            buf_zero    = 1'b0;
            buf_wr_addr = '0;
            buf_rd_addr = '0;
            coef_addr   = '0;
            mac_en      = 1'b0;
            mac_clear   = 1'b0;
            out_wr_en   = 1'b0;
            busy        = 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: models FIFOs, sample RAM, ROM and MAC
// around the DUT and scores results against a shift-register FIR.
module tb_fir_mac_sequencer;

    localparam int TAPS       = 20;
    localparam int DECIMATION = 4;
    localparam int MAC_LAT    = 2;
    localparam int ADDR_W     = $clog2(TAPS);
    localparam int LAT        = TAPS + MAC_LAT + 1;
    localparam int PERIOD     = DECIMATION + TAPS + MAC_LAT + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_empty = 1'b1;
    logic              out_full = 1'b0;
    logic              in_rd_en;
    logic              buf_wr_en;
    logic              buf_zero;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [ADDR_W-1:0] coef_addr;
    logic              mac_en;
    logic              mac_clear;
    logic              out_wr_en;
    logic              busy;

    fir_mac_sequencer #(
        .TAPS(TAPS),
        .DECIMATION(DECIMATION),
        .MAC_LAT(MAC_LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_empty(in_empty),
        .in_rd_en(in_rd_en),
        .buf_wr_en(buf_wr_en),
        .buf_zero(buf_zero),
        .buf_wr_addr(buf_wr_addr),
        .buf_rd_addr(buf_rd_addr),
        .coef_addr(coef_addr),
        .mac_en(mac_en),
        .mac_clear(mac_clear),
        .out_full(out_full),
        .out_wr_en(out_wr_en),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int     fifo[$];
    longint exp_q[$];
    int     coefs[TAPS];
    int     hist[TAPS];
    int     ram[TAPS];
    int     nsamp = 0;

    int     cycle = 0;
    int     tb_wp = 0;
    int     rd_cnt = 0;
    int     init_idx = 0;
    int     mk = TAPS;
    longint acc = 0;
    int     pops = 0;
    int     pushes = 0;
    int     last_pop = 0;
    int     last_push = -1;
    int     stall = 0;
    bit     pending = 0;
    bit     period_chk = 0;
    bit     gap_en = 0;
    bit     rand_full = 0;
    bit     full_force = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_sample(input int s);
        longint sum;
        fifo.push_back(s);
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
        nsamp++;
        if (nsamp % DECIMATION == 0) begin
            sum = 0;
            for (int i = 0; i < TAPS; i++) sum += longint'(coefs[i]) * hist[i];
            exp_q.push_back(sum);
        end
    endtask

    task automatic wait_pushes(input int target, input int budget);
        int n = 0;
        while (pushes < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("push_wait", (pushes >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("pop_wait", (pops >= target) ? 1 : 0, 1);
    endtask

    task automatic flush_model();
        fifo.delete();
        exp_q.delete();
        for (int i = 0; i < TAPS; i++) hist[i] = 0;
        nsamp    = 0;
        tb_wp    = 0;
        rd_cnt   = 0;
        init_idx = 0;
        mk       = TAPS;
        pending  = 0;
    endtask

    // Environment: drives FIFO flags, then mirrors the datapath each cycle.
    initial begin
        longint p;
        forever begin
            @(negedge clock);
            cycle++;
            in_empty = (fifo.size() == 0) ||
                       (gap_en && $urandom_range(3) == 0);
            out_full = full_force || (rand_full && $urandom_range(9) == 0);
            #1;
            if (reset) begin
                check("inv_rd_wr", in_rd_en && out_wr_en, 0);
                check("inv_mac_wr", mac_en && buf_wr_en, 0);
                check("inv_rd_mac", in_rd_en && mac_en, 0);
                check("inv_wr_src", buf_wr_en && !buf_zero && !in_rd_en, 0);
                if (buf_wr_en && buf_zero) begin
                    check("init_addr", buf_wr_addr, init_idx);
                    init_idx++;
                    ram[buf_wr_addr] = 0;
                end
                if (in_rd_en) begin
                    check("pop_empty", in_empty, 0);
                    check("pop_wr_en", buf_wr_en, 1);
                    check("pop_addr", buf_wr_addr, tb_wp);
                    if (fifo.size() == 0) begin
                        check("pop_underflow", 1, 0);
                    end else begin
                        ram[buf_wr_addr] = fifo.pop_front();
                    end
                    tb_wp = (tb_wp + 1) % TAPS;
                    pops++;
                    rd_cnt++;
                    if (rd_cnt == DECIMATION) begin
                        rd_cnt   = 0;
                        last_pop = cycle;
                        stall    = 0;
                        mk       = 0;
                        pending  = 1;
                    end
                end
                if (mac_en) begin
                    check("coef_addr", coef_addr, mk);
                    check("rd_addr", buf_rd_addr, (tb_wp + 2 * TAPS - 1 - mk) % TAPS);
                    check("mac_clear", mac_clear, (mk == 0) ? 1 : 0);
                    check("mac_cycle", cycle, last_pop + 1 + mk);
                    p = longint'(coefs[coef_addr]) * ram[buf_rd_addr];
                    acc = mac_clear ? p : acc + p;
                    mk++;
                end
                if (pending && out_full && (cycle - last_pop) >= LAT) stall++;
                if (out_wr_en) begin
                    check("push_full", out_full, 0);
                    check("latency", cycle - last_pop, LAT + stall);
                    check("mac_count", mk, TAPS);
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        check("fir", acc, exp_q.pop_front());
                    end
                    if (period_chk && last_push >= 0) begin
                        check("period", cycle - last_push, PERIOD);
                    end
                    last_push = cycle;
                    pushes++;
                    pending = 0;
                end
            end
        end
    end

    initial begin
        int pb;
        int pp;
        bit hit;
        for (int i = 0; i < TAPS; i++) begin
            coefs[i] = ((i * 7) % 13) - 6 + i;
            hist[i]  = 0;
            ram[i]   = 0;
        end

        // Held in reset: every output low.
        repeat (3) @(negedge clock);
        #2;
        check("rst_in_rd_en", in_rd_en, 0);
        check("rst_buf_wr_en", buf_wr_en, 0);
        check("rst_buf_zero", buf_zero, 0);
        check("rst_wr_addr", buf_wr_addr, 0);
        check("rst_rd_addr", buf_rd_addr, 0);
        check("rst_coef_addr", coef_addr, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_mac_clear", mac_clear, 0);
        check("rst_out_wr_en", out_wr_en, 0);
        check("rst_busy", busy, 0);

        // Release with an empty FIFO: history zeroing, then idle.
        @(negedge clock);
        reset = 1'b1;
        repeat (TAPS + 5) @(negedge clock);
        #2;
        check("init_count", init_idx, TAPS);
        check("idle_busy", busy, 0);
        check("idle_pops", pops, 0);

        // Continuous input: fixed output period.
        period_chk = 1;
        last_push  = -1;
        for (int i = 0; i < 40; i++) push_sample($urandom_range(65535) - 32768);
        wait_pushes(10, 10 * PERIOD + 100);
        period_chk = 0;

        // Output FIFO full: WRITE holds, no further pops.
        full_force = 1;
        pb = pushes;
        pp = pops;
        for (int i = 0; i < 8; i++) push_sample(i * 1000 - 3500);
        wait_pops(pp + DECIMATION, 200);
        repeat (LAT + 12) @(negedge clock);
        check("full_hold_pops", pops, pp + DECIMATION);
        check("full_hold_push", pushes, pb);
        full_force = 0;
        wait_pushes(pb + 2, 200);

        // Reset in the middle of a MAC pass.
        for (int i = 0; i < DECIMATION; i++) push_sample(777 - i * 300);
        hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clock);
            #1;
            if (mac_en && coef_addr == ADDR_W'(7)) hit = 1;
        end
        check("mac_k7_seen", hit, 1);
        #1;
        reset = 1'b0;
        #1;
        check("abort_mac_en", mac_en, 0);
        check("abort_buf_wr", buf_wr_en, 0);
        check("abort_rd_en", in_rd_en, 0);
        check("abort_out_wr", out_wr_en, 0);
        check("abort_busy", busy, 0);
        flush_model();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (TAPS + 5) @(negedge clock);
        #2;
        check("reinit_count", init_idx, TAPS);
        check("reinit_busy", busy, 0);

        // Random gaps and back-pressure against the golden FIR.
        gap_en    = 1;
        rand_full = 1;
        pb = pushes;
        for (int i = 0; i < 300 * DECIMATION; i++) begin
            push_sample($urandom_range(65535) - 32768);
        end
        wait_pushes(pb + 300, 20000);
        gap_en    = 0;
        rand_full = 0;
        repeat (5) @(negedge clock);
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
